bram_porta_arbiter: RTL and testbench
=====================================

BRAM_PORTA_ARBITER -- requirements
Module: bram_porta_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: BRAM word address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter NUM_COLS, default 4: byte-enable columns per word.
REQ-003 SHALL have parameter COL_WIDTH, default 8: bits per column; DATA_WIDTH = NUM_COLS*COL_WIDTH.
REQ-004 SHALL have a single clock and an asynchronous, active-high reset, named as below.
REQ-005 SHALL have port clk_i, input, 1: single clock.
REQ-006 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have the following bus request ports:
- req_valid_i, input, 1: bus request valid.
- req_ready_o, output, 1: request accepted when valid & ready.
- req_we_i, input, 1: 1 = write, 0 = read.
- req_addr_i, input, ADDR_WIDTH: word address.
- req_be_i, input, NUM_COLS: column write enables.
- req_wdata_i, input, DATA_WIDTH: write data.
REQ-008 SHALL have the following read response ports:
- rsp_valid_o, output, 1: read data valid; no backpressure.
- rsp_rdata_o, output, DATA_WIDTH: read data.
REQ-009 SHALL have the following fill engine ports:
- fill_start_i, input, 1: start a whole-memory fill.
- fill_value_i, input, DATA_WIDTH: fill word, sampled at start.
- fill_busy_o, output, 1: fill in progress.
- fill_done_o, output, 1: one-cycle pulse on fill completion.
REQ-010 SHALL have the following BRAM port A ports:
- bram_addr_o, output, ADDR_WIDTH: port A address.
- bram_we_o, output, NUM_COLS: port A column write enables.
- bram_din_o, output, DATA_WIDTH: port A write data.
- bram_dout_i, input, DATA_WIDTH: port A registered read data, 1-cycle latency.

Function
REQ-011 SHALL implement FSM states IDLE and FILL.
REQ-012 IDLE -> FILL when fill_start_i=1; this takes priority over req_valid_i in the same cycle.
REQ-013 SHALL drive req_ready_o = (state==IDLE) & ~fill_start_i, combinationally.
REQ-014 Accepted write SHALL drive, in the acceptance cycle:
- bram_addr_o = req_addr_i
- bram_we_o = req_be_i
- bram_din_o = req_wdata_i
REQ-015 Accepted read SHALL drive bram_addr_o = req_addr_i and bram_we_o = 0, in the acceptance cycle.
REQ-016 For a read accepted in cycle N, rsp_valid_o SHALL be 1 in cycle N+1 only, with rsp_rdata_o = bram_dout_i.
REQ-017 Write acceptance SHALL NOT assert rsp_valid_o.
REQ-018 Back-to-back requests SHALL be accepted every cycle in IDLE.
REQ-019 bram_we_o SHALL be 0 in any cycle with no accepted write and no fill write.
REQ-020 On entry to FILL: fill_value_i is latched, the address counter is cleared to 0, and fill_busy_o=1 from the next cycle.
REQ-021 Each FILL cycle SHALL drive:
- bram_addr_o = counter
- bram_we_o = all ones
- bram_din_o = latched value
- counter += 1
REQ-022 A fill SHALL write exactly DEPTH consecutive cycles, addresses 0..DEPTH-1, with no skips and no repeats.
REQ-023 After the write to DEPTH-1, the FSM SHALL return to IDLE and pulse fill_done_o for the cycle in which IDLE is re-entered.
REQ-024 fill_busy_o SHALL be 0 in that IDLE cycle, and the counter SHALL NOT wrap into a second pass.
REQ-025 fill_start_i while in FILL SHALL be ignored, with no restart.
REQ-026 A request held valid during FILL SHALL remain pending and be accepted in the first IDLE cycle after the fill.
REQ-027 A read accepted in the last cycle before FILL entry SHALL still produce its rsp_valid_o in the next cycle.

Reset
REQ-028 rst_i assertion SHALL force, immediately and asynchronously:
- state = IDLE
- counter = 0
- latched fill value = 0
- rsp_valid_o = 0
- fill_busy_o = 0
- fill_done_o = 0
REQ-029 Reset during FILL SHALL abort the fill with no fill_done_o pulse, leaving already-written BRAM words unchanged.
REQ-030 A read pending at reset SHALL produce no response.

Configuration
REQ-031 Macro BRAM_PORTA_FILL_EN, when defined, SHALL compile in the fill engine and FILL state as specified.
REQ-032 When BRAM_PORTA_FILL_EN is undefined:
- fill ports SHALL remain present.
- fill_start_i and fill_value_i SHALL be ignored.
- fill_busy_o and fill_done_o SHALL be constant 0.
- req_ready_o SHALL be constant 1.
- no fill counter or fill FSM logic SHALL be present.

Verification
REQ-033 Write then read (ADDR_WIDTH=4):
- stimulus: write addr 3, be 4'b1111, data 32'hDEADBEEF; next cycle read addr 3.
- response: rsp_valid_o one cycle after the read, rsp_rdata_o=32'hDEADBEEF.
REQ-034 Partial write:
- stimulus: write addr 5, data 32'h11223344, be 4'b1111; then write addr 5, data 32'hAABBCCDD, be 4'b0101; then read addr 5.
- response: rsp_rdata_o=32'h11BB33DD.
REQ-035 Fill (macro defined):
- stimulus: fill_start_i with fill_value_i=32'hA5A5A5A5.
- response: fill_busy_o high exactly 16 cycles; bram_we_o=4'hF at addresses 0..15 in order; one fill_done_o pulse; reads of addrs 0 and 15 return 32'hA5A5A5A5.
REQ-036 Collision:
- stimulus: fill_start_i and a read with req_valid_i=1 in the same cycle, read held valid.
- response: req_ready_o=0 for 17 cycles; read accepted on the first cycle after the fill, returning the fill value.
REQ-037 Reset mid-fill:
- stimulus: rst_i asserted after 7 fill writes.
- response: outputs immediately 0 and IDLE; no fill_done_o; addr 8 keeps its prior value.
REQ-038 Macro undefined:
- stimulus: pulse fill_start_i.
- response: req_ready_o stays 1; fill_busy_o and fill_done_o stay 0; no BRAM writes occur.

Source files
------------

// File: rtl/bram_porta_arbiter.sv
// Arbitrates a bus request port and a whole-memory fill engine onto BRAM port A.
// The fill engine and FILL state exist only when BRAM_PORTA_FILL_EN is defined.
module bram_porta_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_COLS   = 4,
  parameter int unsigned COL_WIDTH  = 8,
  localparam int unsigned DATA_WIDTH = NUM_COLS * COL_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_COLS-1:0]   req_be_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  input  logic                  fill_start_i,
  input  logic [DATA_WIDTH-1:0] fill_value_i,
  output logic                  fill_busy_o,
  output logic                  fill_done_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [NUM_COLS-1:0]   bram_we_o,
  output logic [DATA_WIDTH-1:0] bram_din_o,
  input  logic [DATA_WIDTH-1:0] bram_dout_i
);

  logic accept;

  assign accept      = req_valid_i & req_ready_o;
  assign rsp_rdata_o = bram_dout_i;

  // BRAM read data is registered, so the response strobe trails acceptance by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rsp_valid_o <= 1'b0;
    else       rsp_valid_o <= accept & ~req_we_i;
  end

`ifdef BRAM_PORTA_FILL_EN
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  fill_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      counter    <= '0;
      fill_value <= '0;
      fill_done  <= 1'b0;
    end else begin
      state     <= state_next;
      fill_done <= (state == FILL) && (counter == LAST);
      if (state == IDLE && fill_start_i) begin
        counter    <= '0;
        fill_value <= fill_value_i;
      end else if (state == FILL) begin
        counter <= counter + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fill_start_i) state_next = FILL;
      FILL:    if (counter == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready_o = (state == IDLE) & ~fill_start_i;
  assign fill_busy_o = (state == FILL);
  assign fill_done_o = fill_done;

  always_comb begin
    bram_addr_o = req_addr_i;
    bram_we_o   = '0;
    bram_din_o  = req_wdata_i;
    if (state == FILL) begin
      bram_addr_o = counter;
      bram_we_o   = '1;
      bram_din_o  = fill_value;
    end else if (accept && req_we_i) begin
      bram_we_o = req_be_i;
    end
  end
`else
  logic unused_fill;

  assign unused_fill = ^{fill_start_i, fill_value_i};
  assign req_ready_o = 1'b1;
  assign fill_busy_o = 1'b0;
  assign fill_done_o = 1'b0;

  always_comb begin
    bram_addr_o = req_addr_i;
    bram_we_o   = '0;
    bram_din_o  = req_wdata_i;
    if (accept && req_we_i) bram_we_o = req_be_i;
  end
`endif

endmodule

// File: tb/tb_bram_porta_arbiter.sv
// Directed bench for bram_porta_arbiter with a behavioural byte-enable BRAM on port A.
// Fill scenarios run only when BRAM_PORTA_FILL_EN is defined; otherwise the disabled-fill behaviour is checked.
module tb_bram_porta_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        fill_start = 1'b0;
  logic [31:0] fill_value = '0;
  logic        fill_busy;
  logic        fill_done;
  logic [3:0]  bram_addr;
  logic [3:0]  bram_we;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;

  logic [31:0] mem [16];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Read-first BRAM with one-cycle registered read data; not affected by rst.
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++)
      if (bram_we[c]) mem[bram_addr][c*8 +: 8] <= bram_din[c*8 +: 8];
    bram_dout <= mem[bram_addr];
  end

  bram_porta_arbiter #(.ADDR_WIDTH(4), .NUM_COLS(4), .COL_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .fill_start_i(fill_start), .fill_value_i(fill_value),
    .fill_busy_o(fill_busy), .fill_done_o(fill_done),
    .bram_addr_o(bram_addr), .bram_we_o(bram_we), .bram_din_o(bram_din),
    .bram_dout_i(bram_dout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    req_valid = 1'b0; req_we = 1'b0; req_be = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests++; if (fill_busy !== 1'b0) begin fails++; $display("FAIL reset_fill_busy: got %b expected 0", fill_busy); end
    tests++; if (fill_done !== 1'b0) begin fails++; $display("FAIL reset_fill_done: got %b expected 0", fill_done); end
    tests++; if (bram_we !== 4'h0) begin fails++; $display("FAIL reset_bram_we: got %h expected 0", bram_we); end
    step(); step();
    rst = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_be = 4'hF; req_wdata = 32'hDEADBEEF;
    #1;
    tests++; if (bram_we !== 4'hF) begin fails++; $display("FAIL wr_bram_we: got %h expected f", bram_we); end
    tests++; if (bram_addr !== 4'd3) begin fails++; $display("FAIL wr_bram_addr: got %h expected 3", bram_addr); end
    tests++; if (bram_din !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_bram_din: got %h expected deadbeef", bram_din); end
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_no_rsp: got %b expected 0", rsp_valid); end
    req_we = 1'b0; req_be = 4'hF;
    #1;
    tests++; if (bram_we !== 4'h0) begin fails++; $display("FAIL rd_bram_we: got %h expected 0", bram_we); end
    tests++; if (bram_addr !== 4'd3) begin fails++; $display("FAIL rd_bram_addr: got %h expected 3", bram_addr); end
    step();
    idle_bus();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL wr_rd_rsp_valid: got %b expected 1", rsp_valid); end
    tests++; if (rsp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_rd_rdata: got %h expected deadbeef", rsp_rdata); end
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rd_rsp_single: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_partial_write();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_be = 4'hF; req_wdata = 32'h11223344;
    step();
    req_be = 4'b0101; req_wdata = 32'hAABBCCDD;
    step();
    req_we = 1'b0;
    step();
    idle_bus();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL partial_rsp_valid: got %b expected 1", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h11BB33DD) begin fails++; $display("FAIL partial_rdata: got %h expected 11bb33dd", rsp_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_addr = 4'(10 + i); req_wdata = 32'h01010101 * (i + 1);
      #1;
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_wr_ready[%0d]: got %b expected 1", i, req_ready); end
      step();
    end
    req_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 4'(10 + i);
      step();
      exp = 32'h01010101 * (i + 1);
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL b2b_rsp_valid[%0d]: got %b expected 1", i, rsp_valid); end
      tests++; if (rsp_rdata !== exp) begin fails++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, rsp_rdata, exp); end
    end
    idle_bus();
    step();
  endtask

  task automatic test_idle_no_write();
    req_valid = 1'b0; req_we = 1'b1; req_be = 4'hF; req_addr = 4'd3; req_wdata = 32'h0BADF00D;
    #1;
    tests++; if (bram_we !== 4'h0) begin fails++; $display("FAIL idle_bram_we: got %h expected 0", bram_we); end
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL idle_rsp_valid: got %b expected 0", rsp_valid); end
    idle_bus();
  endtask

  task automatic test_reset_pending_read();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    step();
    idle_bus();
    rst = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL pending_read_rsp: got %b expected 0", rsp_valid); end
    step();
    rst = 1'b0;
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL pending_read_late_rsp: got %b expected 0", rsp_valid); end
  endtask

`ifdef BRAM_PORTA_FILL_EN
  task automatic test_fill();
    int busy_cycles;
    busy_cycles = 0;
    fill_start = 1'b1; fill_value = 32'hA5A5A5A5;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL fill_start_ready: got %b expected 0", req_ready); end
    tests++; if (fill_busy !== 1'b0) begin fails++; $display("FAIL fill_start_busy: got %b expected 0", fill_busy); end
    step();
    fill_start = 1'b0; fill_value = 32'h0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (fill_busy === 1'b1) busy_cycles++;
      tests++; if (bram_we !== 4'hF) begin fails++; $display("FAIL fill_we[%0d]: got %h expected f", i, bram_we); end
      tests++; if (bram_addr !== 4'(i)) begin fails++; $display("FAIL fill_addr[%0d]: got %h expected %h", i, bram_addr, 4'(i)); end
      tests++; if (bram_din !== 32'hA5A5A5A5) begin fails++; $display("FAIL fill_din[%0d]: got %h expected a5a5a5a5", i, bram_din); end
      tests++; if (fill_done !== 1'b0) begin fails++; $display("FAIL fill_done_early[%0d]: got %b expected 0", i, fill_done); end
      step();
    end
    tests++; if (busy_cycles != 16) begin fails++; $display("FAIL fill_busy_cycles: got %0d expected 16", busy_cycles); end
    tests++; if (fill_busy !== 1'b0) begin fails++; $display("FAIL fill_end_busy: got %b expected 0", fill_busy); end
    tests++; if (fill_done !== 1'b1) begin fails++; $display("FAIL fill_done_pulse: got %b expected 1", fill_done); end
    tests++; if (bram_we !== 4'h0) begin fails++; $display("FAIL fill_no_wrap: got %h expected 0", bram_we); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
    step();
    tests++; if (fill_done !== 1'b0) begin fails++; $display("FAIL fill_done_single: got %b expected 0", fill_done); end
    tests++; if (rsp_rdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL fill_rd0: got %h expected a5a5a5a5", rsp_rdata); end
    req_addr = 4'd15;
    step();
    idle_bus();
    tests++; if (rsp_rdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL fill_rd15: got %h expected a5a5a5a5", rsp_rdata); end
    step();
  endtask

  task automatic test_collision();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
    fill_value = 32'h5A5A5A5A;
    for (int c = 0; c < 17; c++) begin
      fill_start = (c < 3);  // held during early FILL cycles to show it is ignored
      #1;
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL coll_ready[%0d]: got %b expected 0", c, req_ready); end
      step();
    end
    fill_start = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL coll_ready_after: got %b expected 1", req_ready); end
    tests++; if (fill_done !== 1'b1) begin fails++; $display("FAIL coll_done: got %b expected 1", fill_done); end
    step();
    idle_bus();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL coll_rsp_valid: got %b expected 1", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h5A5A5A5A) begin fails++; $display("FAIL coll_rdata: got %h expected 5a5a5a5a", rsp_rdata); end
    step();
    tests++; if (fill_busy !== 1'b0) begin fails++; $display("FAIL coll_no_restart: got %b expected 0", fill_busy); end
  endtask

  task automatic test_reset_mid_fill();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd8; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
    step();
    req_we = 1'b0;
    step();
    idle_bus();
    fill_start = 1'b1; fill_value = 32'h77777777;
    #1;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL prefill_rsp_valid: got %b expected 1", rsp_valid); end
    tests++; if (rsp_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL prefill_rdata: got %h expected cafef00d", rsp_rdata); end
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    #1;
    tests++; if (fill_busy !== 1'b0) begin fails++; $display("FAIL rstfill_busy: got %b expected 0", fill_busy); end
    tests++; if (bram_we !== 4'h0) begin fails++; $display("FAIL rstfill_we: got %h expected 0", bram_we); end
    tests++; if (fill_done !== 1'b0) begin fails++; $display("FAIL rstfill_done: got %b expected 0", fill_done); end
    step(); step();
    rst = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rstfill_idle: got %b expected 1", req_ready); end
    step();
    tests++; if (fill_done !== 1'b0) begin fails++; $display("FAIL rstfill_no_done: got %b expected 0", fill_done); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd8;
    step();
    tests++; if (rsp_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL rstfill_addr8: got %h expected cafef00d", rsp_rdata); end
    req_addr = 4'd6;
    step();
    tests++; if (rsp_rdata !== 32'h77777777) begin fails++; $display("FAIL rstfill_addr6: got %h expected 77777777", rsp_rdata); end
    req_addr = 4'd7;
    step();
    idle_bus();
    tests++; if (rsp_rdata !== 32'h5A5A5A5A) begin fails++; $display("FAIL rstfill_addr7: got %h expected 5a5a5a5a", rsp_rdata); end
    step();
  endtask
`else
  task automatic test_fill_disabled();
    fill_value = 32'hA5A5A5A5;
    for (int c = 0; c < 20; c++) begin
      fill_start = (c < 2);
      #1;
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL nofill_ready[%0d]: got %b expected 1", c, req_ready); end
      tests++; if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin fails++; $display("FAIL nofill_busy_done[%0d]: got %b%b expected 00", c, fill_busy, fill_done); end
      tests++; if (bram_we !== 4'h0) begin fails++; $display("FAIL nofill_we[%0d]: got %h expected 0", c, bram_we); end
      step();
    end
    fill_start = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    step();
    idle_bus();
    tests++; if (rsp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL nofill_addr3: got %h expected deadbeef", rsp_rdata); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_idle_no_write();
`ifdef BRAM_PORTA_FILL_EN
    test_fill();
    test_collision();
    test_reset_mid_fill();
`else
    test_fill_disabled();
`endif
    test_reset_pending_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
